// File: rtl/alu_result_stage.sv
// Result buffer behind the adder/subtractor: captures sum plus {N,Z,C,V} flags
// into a small FIFO and keeps a saturating count of signed overflows.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  input  logic             in_over,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [7:0]       ovf_count,
  input  logic             clr_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] resultMem [DEPTH];
  logic [3:0]       flagMem   [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      occupancy;
  logic             push;
  logic             pop;
  logic             carryFlag;
  logic [3:0]       newFlags;

  // No bypass: a full buffer refuses input even when the head leaves this cycle.
  assign in_ready  = (occupancy < FULL);
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // For subtraction the adder's carry-out is the inverse of a borrow.
  always_comb begin
    carryFlag = in_sub ? ~in_cout : in_cout;
    newFlags  = {in_s[WIDTH-1], (in_s == '0), carryFlag, in_over};
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      resultMem[wrPtr] <= in_s;
      flagMem[wrPtr]   <= newFlags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
      ovf_count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (PW+1)'(1);
        2'b01:   occupancy <= occupancy - (PW+1)'(1);
        default: occupancy <= occupancy;
      endcase
      if (clr_count)
        ovf_count <= '0;
      else if (push && in_over && (ovf_count != 8'hFF))
        ovf_count <= ovf_count + 8'd1;
    end
  end

  // Outputs read as zero whenever the buffer is empty.
  always_comb begin
    out_result = '0;
    out_flags  = '0;
    if (out_valid) begin
      out_result = resultMem[rdPtr];
      out_flags  = flagMem[rdPtr];
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: spec vectors from a table, directed corner
// sequences, and a cycle-by-cycle queue model checked at every falling edge.
module tb_alu_result_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic             in_cout;
  logic             in_over;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [7:0]       ovf_count;
  logic             clr_count;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } entryT;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             over;
    logic             sub;
    logic [3:0]       flags;
  } vectorT;

  entryT  sbQueue[$];
  vectorT vectors[4];
  int     modelOvf = 0;
  bit     armed = 1'b0;
  bit     doPush;
  bit     doPop;
  int     checks = 0;
  int     errors = 0;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_cout    (in_cout),
    .in_over    (in_over),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .ovf_count  (ovf_count),
    .clr_count  (clr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] expFlags(input logic [WIDTH-1:0] s, input logic cout,
                                          input logic over, input logic sub);
    logic c;
    c = sub ? !cout : cout;
    return {s[WIDTH-1], (s == 0), c, over};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vectorT v);
    nextCycle();
    in_valid = 1'b1;
    in_s     = v.s;
    in_cout  = v.cout;
    in_over  = v.over;
    in_sub   = v.sub;
    nextCycle();
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare the head against the model, then advance the model
  // by what the coming rising edge will do.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("mon_out_valid", out_valid, sbQueue.size() > 0);
      checkOutput("mon_in_ready", in_ready, sbQueue.size() < DEPTH);
      checkOutput("mon_ovf_count", ovf_count, modelOvf);
      if (sbQueue.size() > 0) begin
        checkOutput("mon_out_result", out_result, sbQueue[0].result);
        checkOutput("mon_out_flags", out_flags, sbQueue[0].flags);
      end else begin
        checkOutput("mon_idle_result", out_result, 0);
        checkOutput("mon_idle_flags", out_flags, 0);
      end
    end
    if (!rst_n) begin
      sbQueue.delete();
      modelOvf = 0;
      armed = 1'b1;
    end else if (armed) begin
      doPop  = (sbQueue.size() > 0) && out_ready;
      doPush = in_valid && (sbQueue.size() < DEPTH);
      if (doPop) void'(sbQueue.pop_front());
      if (doPush) sbQueue.push_back('{result: in_s, flags: expFlags(in_s, in_cout, in_over, in_sub)});
      if (clr_count) modelOvf = 0;
      else if (doPush && in_over && modelOvf < 255) modelOvf++;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_s = '0; in_cout = 1'b0; in_over = 1'b0;
    in_sub = 1'b0; out_ready = 1'b1; clr_count = 1'b0;

    vectors[0] = '{s: 16'hFFF4, cout: 1'b0, over: 1'b0, sub: 1'b1, flags: 4'b1010};
    vectors[1] = '{s: 16'h4EF1, cout: 1'b0, over: 1'b0, sub: 1'b0, flags: 4'b0000};
    vectors[2] = '{s: 16'h8000, cout: 1'b0, over: 1'b1, sub: 1'b0, flags: 4'b1001};
    vectors[3] = '{s: 16'h0000, cout: 1'b1, over: 1'b0, sub: 1'b1, flags: 4'b0100};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_result", out_result, 0);
    checkOutput("reset_out_flags", out_flags, 0);
    checkOutput("reset_ovf_count", ovf_count, 0);

    // Each vector must appear on the outputs in the cycle after its push edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vectors[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d_result", i), out_result, vectors[i].s);
      checkOutput($sformatf("vec%0d_flags", i), out_flags, vectors[i].flags);
    end
    checkOutput("table_ovf_count", ovf_count, 1);

    // Backpressure: two accepted, third held until space frees.
    nextCycle();
    out_ready = 1'b0; in_valid = 1'b1; in_s = 16'h1111;
    in_cout = 1'b0; in_over = 1'b0; in_sub = 1'b0;
    nextCycle();
    in_s = 16'h2222;
    nextCycle();
    in_s = 16'h3333;
    @(negedge clk);
    checkOutput("bp_full_ready", in_ready, 0);
    checkOutput("bp_head_a", out_result, 16'h1111);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_a", out_result, 16'h1111);
    end
    nextCycle();
    out_ready = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("bp_drain_b", out_result, 16'h2222);
    checkOutput("bp_ready_again", in_ready, 1);
    nextCycle();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_drain_c", out_result, 16'h3333);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_empty", out_valid, 0);

    // Overflow counter saturation, then clear winning over an overflow push.
    nextCycle();
    clr_count = 1'b1;
    nextCycle();
    clr_count = 1'b0; in_valid = 1'b1; in_over = 1'b1; in_s = 16'h8000; in_sub = 1'b0;
    repeat (256) @(posedge clk);
    #1 clr_count = 1'b1;
    @(negedge clk);
    checkOutput("sat_255", ovf_count, 255);
    nextCycle();
    clr_count = 1'b0; in_valid = 1'b0; in_over = 1'b0;
    @(negedge clk);
    checkOutput("clr_priority", ovf_count, 0);

    // Reset while holding two entries and presenting a third.
    nextCycle();
    out_ready = 1'b0; in_valid = 1'b1; in_over = 1'b1; in_s = 16'h1234;
    nextCycle();
    in_s = 16'h5678;
    nextCycle();
    rst_n = 1'b0; in_s = 16'h9ABC;
    @(negedge clk);
    checkOutput("rst_pre_full", in_ready, 0);
    checkOutput("rst_pre_ovf", ovf_count, 2);
    nextCycle();
    rst_n = 1'b1; in_valid = 1'b0; in_over = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_ovf_count", ovf_count, 0);
    checkOutput("rst_out_result", out_result, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_not_captured", out_valid, 0);

    // Random traffic, checked entirely by the scoreboard.
    for (int i = 0; i < 60; i++) begin
      nextCycle();
      in_valid  = 1'($urandom_range(0, 1));
      in_s      = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      in_cout   = 1'($urandom_range(0, 1));
      in_over   = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      clr_count = ($urandom_range(0, 15) == 0);
    end
    nextCycle();
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the result data width.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the result buffer entry count (power of two, 2..8).
REQ-003 The module SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port in_valid  input  1  upstream adder/subtractor result valid.
REQ-006 The module SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-007 The module SHALL have port in_s  input  WIDTH  sum/difference from the 16-bit adder/subtractor.
REQ-008 The module SHALL have port in_cout  input  1  carry out of the MSB.
REQ-009 The module SHALL have port in_over  input  1  signed overflow (carry into MSB XOR carry out).
REQ-010 The module SHALL have port in_sub  input  1  operation select, i.e. the subtractor cin (0 = add, 1 = subtract).
REQ-011 The module SHALL have port out_valid  output  1  head entry valid.
REQ-012 The module SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-013 The module SHALL have port out_result  output  WIDTH  head entry result.
REQ-014 The module SHALL have port out_flags  output  4  head entry flags {N,Z,C,V}, with N in bit 3.
REQ-015 The module SHALL have port ovf_count  output  8  saturating count of accepted results with V=1.
REQ-016 The module SHALL have port clr_count  input  1  synchronous clear of ovf_count.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 The buffer SHALL be a DEPTH-entry FIFO with wrapping read/write pointers and an occupancy counter 0..DEPTH.
REQ-019 in_ready SHALL be 1 exactly when occupancy < DEPTH; a push while full SHALL be impossible, because there is no bypass (in_ready is low when full even if a pop occurs that cycle).
REQ-020 out_valid SHALL be 1 exactly when occupancy > 0; out_result and out_flags SHALL show the head entry and SHALL be held stable while out_valid && !out_ready.
REQ-021 Latency: a result pushed on edge N SHALL appear on the outputs after edge N (visible in cycle N+1) when the buffer was empty; there SHALL be no combinational in->out path.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-023 Flags SHALL be computed at push time and stored with the entry: N = in_s[WIDTH-1]; Z = (in_s == 0); V = in_over.
REQ-024 C SHALL equal in_cout when in_sub=0, and SHALL equal ~in_cout (borrow) when in_sub=1.
REQ-025 ovf_count SHALL increment by 1 on each push with in_over=1 and SHALL saturate at 255.
REQ-026 When clr_count=1, ovf_count SHALL become 0 on that edge, taking priority over a same-cycle increment.
REQ-027 When out_valid=0, out_result and out_flags SHALL read 0.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL set occupancy, both pointers and ovf_count to 0, out_valid=0, in_ready=1, out_result=0 and out_flags=0.
REQ-029 A reset mid-operation SHALL discard all buffered entries; a push or pop presented in the reset cycle SHALL be ignored.
REQ-030 Buffer storage contents need no reset; only the validity and counter state SHALL be reset.

Verification
REQ-031 The bench SHALL cover: sub 12-24, push in_s=0xFFF4, in_cout=0, in_over=0, in_sub=1 -> next cycle out_result=0xFFF4, out_flags=4'b1010.
REQ-032 The bench SHALL cover: add 17557+2652, push in_s=0x4EF1, in_cout=0, in_over=0, in_sub=0 -> out_flags=4'b0000; add 0x7FFF+0x0001, push 0x8000 with in_over=1 -> out_flags=4'b1001, ovf_count=1.
REQ-033 The bench SHALL cover: sub 5-5, push 0x0000 with in_cout=1 and in_sub=1 -> out_flags=4'b0100 (Z=1, no borrow).
REQ-034 The bench SHALL cover: out_ready=0 with 3 pushes attempted -> the first 2 accepted, in_ready=0 after the second push, the third held upstream; then out_ready=1 -> entries drain in order, with one pop per cycle.
REQ-035 The bench SHALL cover: 256 consecutive pushes with in_over=1 -> ovf_count=255 (no wrap); clr_count=1 together with an overflow push -> ovf_count=0.
REQ-036 The bench SHALL cover: buffer holding 2 entries, rst_n=0 for one cycle while in_valid=1 -> out_valid=0, in_ready=1, ovf_count=0, and the presented entry is not captured.
